run_length_detector: RTL

- Parametrised Mealy detector for runs of identical bits on a serial input `w`.
- Flags every bit that completes, or extends, a run of at least RUN_LEN equal bits.
- A mode input selects polarity: ones, zeros, both, or off.
- Adds input qualification, run-length and match-count observability, and saturating counters. It is the generalised successor of the fixed 4-bit run detector in the serial-input front end.

---
 rtl/run_length_detector_pkg.sv | 20 ++
 rtl/run_length_detector_if.sv | 24 ++
 rtl/run_length_detector_sat_counter.sv | 38 +++
 rtl/run_length_detector.sv | 88 ++++++++
 4 files changed

// File: rtl/run_length_detector_pkg.sv
// Shared definitions for the run-length detector: detect-mode encodings and
// the parameter legality check used at elaboration time.
package run_det_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ONES  = 2'b01,
      MODE_ZEROS = 2'b10,
      MODE_BOTH  = 2'b11
   } mode_e;

   localparam int MIN_RUN_LEN = 2;

   // True when run_len is at least MIN_RUN_LEN and fits in a cnt_w-bit counter.
   function automatic bit run_len_fits(input int run_len, input int cnt_w);
      return (run_len >= MIN_RUN_LEN) &&
             (longint'(run_len) <= ((longint'(1) << cnt_w) - 1));
   endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Serial-bit and observability bundle of the run-length detector.
// The master drives the qualified bit stream; the slave (the detector) answers.
interface run_length_detector_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             w;
   logic [1:0]       mode;
   logic             clr_cnt;
   logic             z;
   logic             z_val;
   logic [CNT_W-1:0] run_len;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output en, w, mode, clr_cnt,
      input  z, z_val, run_len, match_cnt
   );

   modport slave (
      input  en, w, mode, clr_cnt,
      output z, z_val, run_len, match_cnt
   );
endinterface

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear. When clear and
// increment coincide, the clear applies first and the increment still counts.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clke,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end
      if (inc && (q_d != '1)) begin
         q_d = q_d + W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clke) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/run_length_detector.sv
// Mealy detector flagging every qualified bit that completes or extends a run of
// at least RUN_LEN equal bits, with run-length and saturating match-count outputs.
module run_length_detector
   import run_det_pkg::*;
#(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                  clke,
   input  logic                  rst,
   run_length_detector_if.slave  bus
);

   if (!run_len_fits(RUN_LEN, CNT_W)) begin : g_bad_run_len
      $fatal(1, "run_length_detector: RUN_LEN=%0d illegal for CNT_W=%0d", RUN_LEN, CNT_W);
   end
   if ($bits(bus.run_len) != CNT_W) begin : g_bad_bus_width
      $fatal(1, "run_length_detector: interface CNT_W does not match CNT_W=%0d", CNT_W);
   end

   localparam logic [CNT_W-1:0] RUN_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

   logic             have_prev_q, have_prev_d;
   logic             last_bit_q,  last_bit_d;
   logic [CNT_W-1:0] run_len_q,   run_len_d;
   logic [CNT_W-1:0] run_nxt;
   logic             pol_ok;
   logic             z_o;
   logic             match_inc;
   logic [CNT_W-1:0] match_cnt;

   always_comb begin
      // A first bit or a polarity change restarts the run; otherwise extend and saturate.
      run_nxt = RUN_ONE;
      if (have_prev_q && (bus.w == last_bit_q)) begin
         run_nxt = (run_len_q == CNT_MAX) ? CNT_MAX : run_len_q + RUN_ONE;
      end

      case (mode_e'(bus.mode))
         MODE_ONES:  pol_ok = bus.w;
         MODE_ZEROS: pol_ok = ~bus.w;
         MODE_BOTH:  pol_ok = 1'b1;
         default:    pol_ok = 1'b0;
      endcase

      z_o       = bus.en & pol_ok & (run_nxt >= RUN_LEN_C) & ~rst;
      match_inc = bus.en & pol_ok & (run_nxt == RUN_LEN_C);

      have_prev_d = have_prev_q;
      last_bit_d  = last_bit_q;
      run_len_d   = run_len_q;
      if (bus.en) begin
         have_prev_d = 1'b1;
         last_bit_d  = bus.w;
         run_len_d   = run_nxt;
      end
   end

   always_ff @(posedge clke) begin
      if (rst) begin
         have_prev_q <= 1'b0;
         last_bit_q  <= 1'b0;
         run_len_q   <= '0;
      end else begin
         have_prev_q <= have_prev_d;
         last_bit_q  <= last_bit_d;
         run_len_q   <= run_len_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clke (clke),
      .rst  (rst),
      .clr  (bus.clr_cnt),
      .inc  (match_inc),
      .q    (match_cnt)
   );

   assign bus.z         = z_o;
   assign bus.z_val     = z_o & bus.w;
   assign bus.run_len   = run_len_q;
   assign bus.match_cnt = match_cnt;

endmodule
